// File: rtl/edac_pkg.sv
// Shared EDAC definitions: field widths, encoder FSM states and the
// Hamming(12,8) encode function (reused by the matching decoder).
package edac_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned CRC_W = 4;
    localparam int unsigned CW_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Hamming(12,8): data at h2,h4,h5,h6,h8..h11; parity at h0,h1,h3,h7.
    function automatic logic [CW_W-1:0] hamming12_enc(input logic [7:0] d);
        logic [CW_W-1:0] h;
        h      = '0;
        h[2]   = d[0];
        h[4]   = d[1];
        h[5]   = d[2];
        h[6]   = d[3];
        h[8]   = d[4];
        h[9]   = d[5];
        h[10]  = d[6];
        h[11]  = d[7];
        h[0]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        h[1]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        h[3]   = d[1] ^ d[2] ^ d[3] ^ d[7];
        h[7]   = d[4] ^ d[5] ^ d[6] ^ d[7];
        return h;
    endfunction

endpackage

// File: rtl/edac_crc4_lane.sv
// Bit-serial CRC-4 register for one nibble lane.
// Ports: clk, rst_n; clear zeroes the register; shift folds bit_in in
// using generator poly (implicit x^4 term); crc is the current remainder.
module edac_crc4_lane
    import edac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic             fb_c;

    assign fb_c = bit_in ^ crc_q[CRC_W-1];
    assign crc  = crc_q;

    // Clear has priority so a new word always starts from a zero remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (shift) begin
            crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? poly : CRC_W'(0));
        end
    end

endmodule

// File: rtl/edac_encode_stream.sv
// Streaming CRC-4 + Hamming(12,8) encoder.
// Ports: clk, rst_n; in_valid/in_ready/din/crc_poly/crc_en input word
// handshake; out_valid/out_ready/dout registered codeword output;
// busy is high whenever the FSM is not IDLE.
module edac_encode_stream
    import edac_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] din,
    input  logic [CRC_W-1:0]         crc_poly,
    input  logic                     crc_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW_W*NIBBLES-1:0]  dout,
    output logic                     busy
);

    localparam int unsigned CNT_W = 2;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NIBBLES-1:0][NIB_W-1:0]   nib_q;
    logic [CRC_W-1:0]                poly_q;
    logic [NIBBLES-1:0][CRC_W-1:0]   crc_c;
    logic [NIBBLES-1:0][CW_W-1:0]    cw_c;
    logic [NIBBLES-1:0][CW_W-1:0]    dout_q, dout_d;
    logic                            out_valid_q, out_valid_d;
    logic                            in_ready_q, in_ready_d;
    logic                            busy_q, busy_d;
    logic                            accept_c;
    logic                            shift_c;

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

    // One CRC lane per nibble, all fed MSB first from the latched word.
    for (genvar i = 0; i < int'(NIBBLES); i++) begin : g_lane
        edac_crc4_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (accept_c),
            .shift  (shift_c),
            .bit_in (nib_q[i][CNT_W'(3) - cnt_q]),
            .poly   (poly_q),
            .crc    (crc_c[i])
        );
        assign cw_c[i] = hamming12_enc({nib_q[i], crc_c[i]});
    end

    // Next-state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        accept_c    = 1'b0;
        shift_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = crc_en ? CRC : DONE;
                end
            end
            CRC: begin
                shift_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle captures codewords; then wait for handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    dout_d      = cw_c;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Word capture; later input changes cannot disturb the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q  <= '0;
            poly_q <= '0;
        end else if (accept_c) begin
            nib_q  <= din;
            poly_q <= crc_poly;
        end
    end

endmodule

// File: tb/tb_edac_encode_stream.sv
module tb_edac_encode_stream;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4*N-1:0]  din;
    logic [3:0]    crc_poly;
    logic          crc_en;
    logic          out_valid;
    logic          out_ready;
    logic [12*N-1:0] dout;
    logic          busy;

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] EXP_CRC   = 48'h000_F11_000_19F;
    localparam logic [47:0] EXP_NOCRC = 48'h000_F08_000_181;
    localparam logic [47:0] EXP_ONE   = 48'h000_000_000_19F;

    always #5 clk = ~clk;

    edac_encode_stream #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .crc_poly  (crc_poly),
        .crc_en    (crc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    // Reference model built from the bit-level definitions.
    function automatic logic [3:0] ref_crc(input logic [3:0] n, input logic [3:0] p);
        logic [3:0] r;
        logic       fb;
        r = 4'h0;
        for (int k = 0; k < 4; k++) begin
            fb = n[3-k] ^ r[3];
            r  = {r[2:0], 1'b0} ^ (fb ? p : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [11:0] ref_ham(input logic [7:0] d);
        logic [11:0] h;
        h = {d[7], d[6], d[5], d[4],
             d[4] ^ d[5] ^ d[6] ^ d[7],
             d[3], d[2], d[1],
             d[1] ^ d[2] ^ d[3] ^ d[7],
             d[0],
             d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6],
             d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
        return h;
    endfunction

    function automatic logic [47:0] ref_word(input logic [15:0] d, input logic [3:0] p, input logic e);
        logic [47:0] w;
        logic [3:0]  nib;
        logic [3:0]  c;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            nib = d[4*i +: 4];
            c   = e ? ref_crc(nib, p) : 4'h0;
            w[12*i +: 12] = ref_ham({nib, c});
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold in_valid until the accepting edge (bounded).
    task automatic send(input logic [15:0] d, input logic [3:0] p, input logic e, output bit ok);
        din      = d;
        crc_poly = p;
        crc_en   = e;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        crc_poly  = 4'h0;
        crc_en    = 1'b0;
        out_ready = 1'b0;
        #12;
        checks++;
        if ({dout, out_valid, busy} !== {48'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h ov=%b busy=%b, want 0/0/0", dout, out_valid, busy);
        end
        #3 rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_crc_basic();
        bit ok;
        out_ready = 1'b1;
        send(16'h0F01, 4'h3, 1'b1, ok);
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL crc_accept: ok=%b busy=%b, want 1/1", ok, busy);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL crc_latency T+%0d: ov=%b busy=%b, want 0/1", k, out_valid, busy);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || dout !== EXP_CRC || busy !== 1'b1) begin
            errors++;
            $display("FAIL crc_out T+5: ov=%b dout=%h busy=%b, want 1 %h 1", out_valid, dout, busy, EXP_CRC);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || dout !== EXP_CRC) begin
            errors++;
            $display("FAIL crc_handshake: ov=%b busy=%b rdy=%b dout=%h, want 0 0 1 %h", out_valid, busy, in_ready, dout, EXP_CRC);
        end
    endtask

    task automatic test_nocrc();
        bit ok;
        out_ready = 1'b1;
        send(16'h0F01, 4'h3, 1'b0, ok);
        checks++;
        if (!ok || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nocrc_accept: ok=%b ov=%b, want 1/0", ok, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || dout !== EXP_NOCRC) begin
            errors++;
            $display("FAIL nocrc_out T+1: ov=%b dout=%h, want 1 %h", out_valid, dout, EXP_NOCRC);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL nocrc_done: ov=%b rdy=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        bit ok;
        out_ready = 1'b0;
        send(16'h0F01, 4'h3, 1'b1, ok);
        wait_out(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_wait: out_valid never rose, got 0 want 1");
        end
        din      = 16'h0F01;
        crc_poly = 4'h3;
        crc_en   = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (dout !== EXP_CRC || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d: dout=%h ov=%b rdy=%b, want %h 1 0", c, dout, out_valid, in_ready, EXP_CRC);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ov=%b rdy=%b, want 0/1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_second_accept: rdy=%b busy=%b, want 0/1", in_ready, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || dout !== EXP_NOCRC) begin
            errors++;
            $display("FAIL stall_second_out: ov=%b dout=%h, want 1 %h", out_valid, dout, EXP_NOCRC);
        end
        step();
    endtask

    task automatic test_isolation();
        bit ok;
        out_ready = 1'b1;
        send(16'h0F01, 4'h3, 1'b1, ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            din      = 16'($urandom);
            crc_poly = 4'($urandom);
            crc_en   = 1'($urandom);
            step();
        end
        checks++;
        if (!ok || dout !== EXP_CRC) begin
            errors++;
            $display("FAIL isolation: ov=%b dout=%h, want 1 %h", ok, dout, EXP_CRC);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        send(16'h0F01, 4'h5, 1'b1, ok);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 48'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: dout=%h ov=%b busy=%b, want 0 0 0", dout, out_valid, busy);
        end
        #10 rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: rdy=%b ov=%b, want 1/0", in_ready, out_valid);
        end
        send(16'h0001, 4'h3, 1'b1, ok);
        wait_out(10, ok);
        checks++;
        if (!ok || dout !== EXP_ONE) begin
            errors++;
            $display("FAIL reset_mid_fresh: ov=%b dout=%h, want 1 %h", ok, dout, EXP_ONE);
        end
        step();
    endtask

    task automatic test_random();
        bit          ok;
        logic [15:0] d;
        logic [3:0]  p;
        logic        e;
        logic [47:0] exp_w;
        for (int w = 0; w < 1000; w++) begin
            d = 16'($urandom);
            p = 4'($urandom);
            e = ($urandom_range(0, 3) != 0);
            exp_w = ref_word(d, p, e);
            repeat ($urandom_range(0, 2)) step();
            out_ready = 1'b0;
            send(d, p, e, ok);
            wait_out(10, ok);
            repeat ($urandom_range(0, 3)) step();
            checks++;
            if (!ok || out_valid !== 1'b1 || dout !== exp_w) begin
                errors++;
                $display("FAIL random w%0d: ov=%b dout=%h, want 1 %h (din=%h poly=%h en=%b)", w, out_valid, dout, exp_w, d, p, e);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || dout !== exp_w) begin
                errors++;
                $display("FAIL random_post w%0d: ov=%b dout=%h, want 0 %h", w, out_valid, dout, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_basic();
        test_nocrc();
        test_stall();
        test_isolation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
